aes_round_sequencer: RTL and testbench

Iterative AES encryption controller that owns the 128-bit state register and sequences one cipher round per clock over the shared round datapath. The SubBytes+ShiftRows and MixColumns units are external combinational blocks driven through ports. The round-key XOR is instantiated internally. The block fetches round keys from an external key store by index and exposes valid/ready handshakes on both the plaintext input and the ciphertext output.

---
 rtl/aes_seq_pkg.sv | 20 ++
 rtl/aes_round_sequencer_round_key_xor.sv | 16 +
 rtl/aes_round_sequencer.sv | 143 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: definitions shared by the AES round sequencer files.
//   - seq_state_e : sequencer FSM encoding (IDLE, ROUND, FINAL, DONE)
//   - AES_BLOCK_W : AES block / state width in bits
//   - NR_AES*     : round counts for the three AES key sizes
package aes_seq_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer_round_key_xor.sv
// round_key_xor: AddRoundKey step, a plain 128-bit XOR of data and round key.
// Ports:
//   data_i : block entering AddRoundKey
//   key_i  : round key
//   data_o : data_i ^ key_i
module round_key_xor
    import aes_seq_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] data_i,
    input  logic [AES_BLOCK_W-1:0] key_i,
    output logic [AES_BLOCK_W-1:0] data_o
);

    assign data_o = data_i ^ key_i;

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES encryption controller. It owns the
// 128-bit state register and runs one cipher round per clock. The
// SubBytes+ShiftRows and MixColumns units are external and combinational.
// Round keys come from an external key store that is addressed by rk_index.
//
// Ports:
//   clk, reset             : clock; asynchronous active-high reset
//   start_valid/ready      : plaintext handshake (ready only in IDLE)
//   plaintext              : sampled on the accepting edge only
//   rk_index / rk_data     : key store address / key data (same cycle)
//   sub_in / sub_out       : state to / result from SubBytes+ShiftRows
//   mix_in / mix_out       : sub_out to / result from MixColumns
//   out_valid/out_ready    : ciphertext handshake
//   ciphertext             : the state register
//   abort                  : only with SEQ_ABORT_EN defined; drops the
//                            block in flight and returns to IDLE
//
// Build option: define SEQ_ABORT_EN to add the abort input.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = NR_AES128,
    parameter int RIDX_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [127:0]      plaintext,
    output logic [RIDX_W-1:0] rk_index,
    input  logic [127:0]      rk_data,
    output logic [127:0]      sub_in,
    input  logic [127:0]      sub_out,
    output logic [127:0]      mix_in,
    input  logic [127:0]      mix_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      ciphertext
);

    seq_state_e               state_q;
    logic [RIDX_W-1:0]        rnd_q;
    logic [AES_BLOCK_W-1:0]   state_reg_q;
    logic                     out_valid_q;
    logic                     start_ready_q;

    logic                     abort_w;
    logic [AES_BLOCK_W-1:0]   xor_din;
    logic [AES_BLOCK_W-1:0]   xor_dout;

`ifdef SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // A single AddRoundKey unit serves every round. Its data input is selected
    // by phase: plaintext for round 0, MixColumns output for the middle
    // rounds, and SubBytes+ShiftRows output for the last round.
    always_comb begin
        xor_din = mix_out;
        case (state_q)
            IDLE:    xor_din = plaintext;
            FINAL:   xor_din = sub_out;
            default: xor_din = mix_out;
        endcase
    end

    round_key_xor u_rkx (
        .data_i (xor_din),
        .key_i  (rk_data),
        .data_o (xor_dout)
    );

    always_comb begin
        rk_index = RIDX_W'(NUM_ROUNDS);
        case (state_q)
            IDLE:    rk_index = '0;
            ROUND:   rk_index = rnd_q;
            default: rk_index = RIDX_W'(NUM_ROUNDS);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rnd_q         <= '0;
            state_reg_q   <= '0;
            out_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
        end else if (abort_w && state_q != IDLE) begin
            // abort takes priority over out_ready in DONE
            state_q       <= IDLE;
            rnd_q         <= '0;
            state_reg_q   <= '0;
            out_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid && start_ready_q) begin
                        state_reg_q   <= xor_dout;
                        rnd_q         <= RIDX_W'(1);
                        start_ready_q <= 1'b0;
                        state_q       <= (NUM_ROUNDS == 1) ? FINAL : ROUND;
                    end
                end
                ROUND: begin
                    state_reg_q <= xor_dout;
                    rnd_q       <= rnd_q + RIDX_W'(1);
                    if (rnd_q == RIDX_W'(NUM_ROUNDS - 1))
                        state_q <= FINAL;
                end
                FINAL: begin
                    state_reg_q <= xor_dout;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // the state register holds its value until the consumer
                    // takes the ciphertext
                    if (out_ready) begin
                        state_q       <= IDLE;
                        rnd_q         <= '0;
                        out_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign out_valid   = out_valid_q;
    assign ciphertext  = state_reg_q;
    assign sub_in      = state_reg_q;
    assign mix_in      = sub_out;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk, reset, start_valid, start_ready, out_valid, out_ready, abort_s;
  logic [127:0] plaintext, rk_data, sub_in, sub_out, mix_in, mix_out, ciphertext;
  logic [3:0]   rk_index;
  logic [127:0] key;

  int n_chk, n_pass, cyc;
  bit m_busy;
  int m_k;
  logic [127:0] m_ct;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // S-box from the field inverse (a^254) followed by the affine map
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv, p;
    inv = 8'h01; p = a;
    for (int i = 0; i < 7; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    if (r < 0 || r > 10) return '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s;
    s = pt ^ round_key(k, 0);
    for (int r = 1; r < NR; r++) s = mix_cols(sub_shift(s)) ^ round_key(k, r);
    return sub_shift(s) ^ round_key(k, NR);
  endfunction

  // ---------------- external units and key store ----------------
  assign rk_data = round_key(key, int'(rk_index));
  assign sub_out = sub_shift(sub_in);
  assign mix_out = mix_cols(mix_in);

  aes_round_sequencer #(.NUM_ROUNDS(NR), .RIDX_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef SEQ_ABORT_EN
    .abort       (abort_s),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .plaintext   (plaintext),
    .rk_index    (rk_index),
    .rk_data     (rk_data),
    .sub_in      (sub_in),
    .sub_out     (sub_out),
    .mix_in      (mix_in),
    .mix_out     (mix_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ciphertext  (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // call at a negedge; returns #1 after the accepting edge
  task automatic send(input logic [127:0] pt, input bit keep, output int acc);
    bit done;
    done = 0; acc = -1;
    plaintext = pt; start_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (start_ready) begin
        @(posedge clk); #1;
        acc = cyc; done = 1;
      end else @(negedge clk);
    end
    if (!keep) start_valid = 1'b0;
    if (!done) chk("accept timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_valid(output int vc);
    bit done;
    done = 0; vc = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (out_valid) begin vc = cyc; done = 1; end
    end
    if (!done) chk("out_valid timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_rk(input logic [3:0] v);
    bit done;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (rk_index == v) done = 1;
    end
    if (!done) chk("rk_index wait timeout", 128'd0, 128'd1);
  endtask

  int acc, acc2, vc, vc2;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    m_busy = 0; m_k = 0; m_ct = '0;
    reset = 1'b1; start_valid = 1'b0; plaintext = '0; out_ready = 1'b1;
    abort_s = 1'b0; key = K_B;

    fork
      // transaction-level model: a block is busy from its accept until its
      // ciphertext is taken; valid once NR edges have passed since accept
      forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
          m_busy = 0; m_k = 0;
        end else begin
          cyc++;
          if (!m_busy) begin
            if (start_valid) begin
              m_busy = 1; m_k = 0; m_ct = aes_enc(plaintext, key);
            end
          end else if (abort_s) m_busy = 0;
          else if (m_k == NR) begin
            if (out_ready) m_busy = 0;
          end else m_k++;
        end
      end
      forever begin
        @(negedge clk);
        if (!reset) begin
          chk("cmp out_valid", 128'(out_valid), 128'(m_busy && m_k == NR));
          chk("cmp start_ready", 128'(start_ready), 128'(!m_busy));
          chk("cmp rk_index", 128'(rk_index),
              !m_busy ? 128'd0 : (m_k < NR - 1 ? 128'(m_k + 1) : 128'(NR)));
          if (m_busy && m_k == NR) chk("cmp ciphertext", ciphertext, m_ct);
        end
      end
    join_none

    // reset state
    repeat (2) @(negedge clk);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset start_ready", 128'(start_ready), 128'd1);
    chk("reset ciphertext", ciphertext, 128'd0);
    chk("reset rk_index", 128'(rk_index), 128'd0);
    reset = 1'b0;

    // pin the reference model to published vectors
    chk("model appB ct", aes_enc(PT_B, K_B), CT_B);
    chk("model C1 ct", aes_enc(PT_C, K_C), CT_C);
    chk("model appB rk10", round_key(K_B, 10), RK10_B);

    // FIPS-197 App. B with latency check
    @(negedge clk);
    send(PT_B, 0, acc);
    wait_valid(vc);
    chk("appB latency", 128'(vc - acc), 128'd10);
    chk("appB ct", ciphertext, CT_B);
    @(negedge clk);

    // FIPS-197 C.1 with rk_index walk
    key = K_C;
    chk("C1 rk_index idle", 128'(rk_index), 128'd0);
    send(PT_C, 0, acc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("C1 rk_index step", 128'(rk_index), (k < 9) ? 128'(k + 1) : 128'd10);
    end
    wait_valid(vc);
    chk("C1 ct", ciphertext, CT_C);
    @(negedge clk);

    // backpressure in DONE
    key = K_B; out_ready = 1'b0;
    send(PT_B, 0, acc);
    wait_valid(vc);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 128'(out_valid), 128'd1);
      chk("bp ct stable", ciphertext, CT_B);
      chk("bp start_ready", 128'(start_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 128'(out_valid), 128'd0);
    chk("bp release start_ready", 128'(start_ready), 128'd1);
    @(negedge clk);

    // back-to-back with start_valid held
    key = K_C;
    send(PT_C, 1, acc);
    plaintext = PT_B;
    wait_valid(vc);
    chk("b2b first ct", ciphertext, CT_C);
    @(posedge clk); #1;
    chk("b2b idle after handshake", 128'(start_ready), 128'd1);
    @(posedge clk); #1;
    acc2 = cyc;
    chk("b2b second accepted", 128'(start_ready), 128'd0);
    chk("b2b accept spacing", 128'(acc2 - vc), 128'd2);
    start_valid = 1'b0;
    wait_valid(vc2);
    chk("b2b second ct", ciphertext, aes_enc(PT_B, K_C));
    chk("b2b second latency", 128'(vc2 - acc2), 128'd10);
    @(negedge clk);

    // asynchronous reset at rnd=5
    key = K_B;
    send(PT_B, 0, acc);
    wait_rk(4'd5);
    #2 reset = 1'b1;
    #1;
    chk("areset out_valid", 128'(out_valid), 128'd0);
    chk("areset start_ready", 128'(start_ready), 128'd1);
    chk("areset ciphertext", ciphertext, 128'd0);
    chk("areset rk_index", 128'(rk_index), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(PT_B, 0, acc);
    wait_valid(vc);
    chk("post-reset appB ct", ciphertext, CT_B);
    @(negedge clk);

`ifdef SEQ_ABORT_EN
    // abort at rnd=3, then a clean C.1 run
    send(PT_B, 0, acc);
    wait_rk(4'd3);
    abort_s = 1'b1;
    @(posedge clk); #1;
    chk("abort out_valid", 128'(out_valid), 128'd0);
    chk("abort start_ready", 128'(start_ready), 128'd1);
    chk("abort ciphertext", ciphertext, 128'd0);
    chk("abort rk_index", 128'(rk_index), 128'd0);
    @(negedge clk);
    abort_s = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) chk("abort no valid", 128'd1, 128'd0);
    end
    key = K_C;
    send(PT_C, 0, acc);
    wait_valid(vc);
    chk("post-abort C1 ct", ciphertext, CT_C);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
